// File: rtl/opcode_sequencer.sv
// opcode_sequencer: holds a short program of 2-bit opcodes and issues them
// one per accepted valid/ready transfer to the control-word decoder.
// Supports looping back to address 0, abort via stop, a completion pulse,
// a write-error pulse and a wrapping 8-bit issue counter.
module opcode_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] prog_last,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic [1:0]    op_out,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          wr_err,
    output logic [7:0]    issue_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] last;
    logic          loop;
    logic          wr_err_q;
    logic          xfer;
    logic          at_last;

    assign xfer    = (state == RUN) && op_ready;
    assign at_last = (pc == last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: stop wins over finishing the program in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (stop)                          state_nxt = IDLE;
                else if (xfer && at_last && !loop) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Program counter, latched program bounds and issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            last      <= '0;
            loop      <= 1'b0;
            issue_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc        <= '0;
                        last      <= prog_last;
                        loop      <= loop_en;
                        issue_cnt <= 8'd0;
                    end
                end
                RUN: begin
                    // a transfer coinciding with stop is still counted
                    if (xfer) issue_cnt <= issue_cnt + 8'd1;
                    if (stop)              pc <= '0;
                    else if (xfer) begin
                        if (!at_last)      pc <= pc + 1'b1;
                        else if (loop)     pc <= '0;
                    end
                end
                DONE:    pc <= '0;
                default: pc <= '0;
            endcase
        end
    end

    // Program memory: cleared on reset, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
        end else if (wr_en && (state == IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Flag writes attempted while a program is running or finishing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_en && (state != IDLE);
    end

    assign op_valid = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign wr_err   = wr_err_q;
    assign op_out   = op_valid ? mem[pc] : 2'b00;

endmodule
